mac: RTL and testbench

MAC -- requirements
Module: mac

---
 rtl/mac_pkg.sv | 10 +
 rtl/mac_mult.sv | 22 ++
 rtl/mac.sv | 62 ++++++
 tb/tb_mac.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared defaults and signed accumulator limits for the multiply-accumulate block.
package mac_pkg;

    localparam int unsigned DEF_DATA_W = 4;
    localparam int unsigned DEF_ACC_W  = 12;

    localparam logic signed [DEF_ACC_W-1:0] ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
    localparam logic signed [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

endpackage

// File: rtl/mac_mult.sv
// Combinational signed DATA_W x DATA_W multiplier with a full-precision 2*DATA_W result.
module mac_mult
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic signed [DATA_W-1:0]   a,
    input  logic signed [DATA_W-1:0]   b,
    output logic signed [2*DATA_W-1:0] prod_c
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    // Widen both operands first so (-2^(DATA_W-1))^2 keeps its positive sign.
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;

    assign a_ext  = PROD_W'(a);
    assign b_ext  = PROD_W'(b);
    assign prod_c = a_ext * b_ext;

endmodule

// File: rtl/mac.sv
// Signed multiply-accumulate: acc <= acc + IN*W every cycle, with optional saturation.
module mac
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ACC_W    = DEF_ACC_W,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic signed [DATA_W-1:0] IN,
    input  logic signed [DATA_W-1:0] W,
    output logic signed [ACC_W-1:0]  OUT
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned SUM_W  = ACC_W + 1;

    localparam logic signed [ACC_W-1:0] LIM_HI = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] LIM_LO = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W-1:0]  acc;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [SUM_W-1:0]  prod_ext_c;
    logic signed [SUM_W-1:0]  acc_ext_c;
    logic signed [SUM_W-1:0]  sum_c;
    logic                     ovf_c;
    logic signed [ACC_W-1:0]  acc_next_c;

    mac_mult #(
        .DATA_W (DATA_W)
    ) u_mult (
        .a      (IN),
        .b      (W),
        .prod_c (prod_c)
    );

    // One guard bit is enough: |product| <= 2^(ACC_W-2) when ACC_W >= 2*DATA_W.
    assign prod_ext_c = SUM_W'(prod_c);
    assign acc_ext_c  = SUM_W'(acc);
    assign sum_c      = acc_ext_c + prod_ext_c;
    assign ovf_c      = sum_c[SUM_W-1] ^ sum_c[ACC_W-1];

    always_comb begin
        acc_next_c = sum_c[ACC_W-1:0];
        if (SATURATE && ovf_c) begin
            acc_next_c = sum_c[SUM_W-1] ? LIM_LO : LIM_HI;
        end
    end

    // Accumulator register; synchronous reset discards the operands of that edge.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            acc <= '0;
        end else begin
            acc <= acc_next_c;
        end
    end

    assign OUT = acc;

endmodule

// File: tb/tb_mac.sv
// Directed bench for mac: wrapping and saturating instances driven by shared operands.
module tb_mac;

    logic              clk;
    logic              rstb;
    logic signed [3:0] din;
    logic signed [3:0] wt;
    logic signed [11:0] out_wrap;
    logic signed [11:0] out_sat;

    int n_checks;
    int n_pass;

    mac #(.DATA_W(4), .ACC_W(12), .SATURATE(1'b0)) dut_wrap (
        .clk  (clk),
        .rstb (rstb),
        .IN   (din),
        .W    (wt),
        .OUT  (out_wrap)
    );

    mac #(.DATA_W(4), .ACC_W(12), .SATURATE(1'b1)) dut_sat (
        .clk  (clk),
        .rstb (rstb),
        .IN   (din),
        .W    (wt),
        .OUT  (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive operands mid-cycle, then let one rising edge pass and settle.
    task automatic step(input logic rb, input int a, input int b);
        @(negedge clk);
        rstb = rb;
        din  = 4'(a);
        wt   = 4'(b);
        @(posedge clk);
        #1;
    endtask

    function automatic int wrap12(input int v);
        logic signed [11:0] t;
        t = 12'(v);
        return int'(t);
    endfunction

    function automatic int clamp12(input int v);
        if (v > 2047)  return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    int seq_a [9]  = '{4, -1, 2, 1, -3, 3, -2, 2, -4};
    int seq_b [9]  = '{3, 2, -2, 1, 1, -1, 2, -3, -4};
    int seq_e [9]  = '{12, 10, 6, 7, 4, 1, -3, -9, 7};
    int run_a [11] = '{1, -1, 2, -2, 3, -3, 4, -4, 1, -1, 2};
    int run_b [11] = '{1, -1, 2, -2, 3, -3, 4, -4, -1, 1, -2};
    int run_e [11] = '{17, 18, 22, 26, 35, 44, 60, 76, 75, 74, 70};

    int m_wrap;
    int m_sat;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rstb = 1'b0;
        din  = '0;
        wt   = '0;

        step(1'b0, 0, 0);
        check("reset_wrap", int'(out_wrap), 0);
        check("reset_sat", int'(out_sat), 0);

        for (int i = 0; i < 2; i++) begin
            step(1'b1, 0, 0);
            check("idle_zero_wrap", int'(out_wrap), 0);
            check("idle_zero_sat", int'(out_sat), 0);
        end

        for (int i = 0; i < 9; i++) begin
            step(1'b1, seq_a[i], seq_b[i]);
            check($sformatf("seq%0d_wrap", i), int'(out_wrap), seq_e[i]);
            check($sformatf("seq%0d_sat", i), int'(out_sat), seq_e[i]);
        end

        step(1'b1, 5, 0);
        check("w_zero_hold", int'(out_wrap), 7);
        step(1'b1, 0, -5);
        check("in_zero_hold", int'(out_wrap), 7);

        step(1'b0, -4, -4);
        check("midrun_reset_wrap", int'(out_wrap), 0);
        check("midrun_reset_sat", int'(out_sat), 0);
        step(1'b1, -4, -4);
        check("first_after_reset", int'(out_wrap), 16);
        check("extreme_product_sat", int'(out_sat), 16);

        for (int i = 0; i < 11; i++) begin
            step(1'b1, run_a[i], run_b[i]);
            check($sformatf("run%0d_wrap", i), int'(out_wrap), run_e[i]);
            check($sformatf("run%0d_sat", i), int'(out_sat), run_e[i]);
        end

        step(1'b0, 0, 0);
        check("ovf_reset", int'(out_wrap), 0);
        m_wrap = 0;
        m_sat  = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1'b1, -8, -8);
            m_wrap = wrap12(m_wrap + 64);
            m_sat  = clamp12(m_sat + 64);
            check($sformatf("pos_ovf%0d_wrap", k), int'(out_wrap), m_wrap);
            check($sformatf("pos_ovf%0d_sat", k), int'(out_sat), m_sat);
            if (k == 31) check("wrap_peak_1984", int'(out_wrap), 1984);
            if (k == 32) begin
                check("wrap_to_min", int'(out_wrap), -2048);
                check("sat_hold_max", int'(out_sat), 2047);
            end
        end
        check("sat_max_final", int'(out_sat), 2047);

        for (int k = 1; k <= 80; k++) begin
            step(1'b1, -8, 7);
            m_wrap = wrap12(m_wrap - 56);
            m_sat  = clamp12(m_sat - 56);
            check($sformatf("neg_ovf%0d_wrap", k), int'(out_wrap), m_wrap);
            check($sformatf("neg_ovf%0d_sat", k), int'(out_sat), m_sat);
        end
        check("sat_min_final", int'(out_sat), -2048);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
